// File: rtl/mant_norm_sched_pkg.sv
// ---------------------------------------------------------------------------
// mant_norm_sched_pkg
// Shared helpers for the mantissa-normalization scheduler.
//   id_width(n)  : width of a requester index, at least 1 bit.
//   lzc_width(w) : width needed to hold a leading-zero count of 0..w.
// ---------------------------------------------------------------------------
package mant_norm_sched_pkg;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mant_norm_sched_if.sv
// ---------------------------------------------------------------------------
// mant_norm_sched_if
// Requester-side and result-side handshake bundle of the scheduler.
//   req_valid_i   : per-requester operand valid
//   req_ready_o   : per-requester accept (one-hot or zero)
//   req_operand_i : per-requester unnormalized operand
//   out_valid_o / out_ready_i : result handshake to the rounding stage
//   out_id_o      : originating requester index
//   out_exp_o     : signed normalization exponent
//   out_mant_o    : normalized mantissa
//   out_zero_o    : operand was all zeros
// Modports: slave = scheduler, master = requesters + downstream consumer.
// ---------------------------------------------------------------------------
interface mant_norm_sched_if
    import mant_norm_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 3
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_operand_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [ID_W-1:0]               out_id_o;
    logic signed [EXP_WIDTH:0]     out_exp_o;
    logic [WIDTH-1:0]              out_mant_o;
    logic                          out_zero_o;

    modport slave (
        input  req_valid_i, req_operand_i, out_ready_i,
        output req_ready_o, out_valid_o, out_id_o, out_exp_o, out_mant_o, out_zero_o
    );

    modport master (
        output req_valid_i, req_operand_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_id_o, out_exp_o, out_mant_o, out_zero_o
    );

endinterface

// File: rtl/mant_norm.sv
// ---------------------------------------------------------------------------
// mant_norm
// Combinational mantissa normalizer.
//   operand : unnormalized fixed-point value, DOT_BITS integer digits
//   exp_val : DOT_BITS-1-lzc as signed two's complement (0 for a zero operand)
//   mant    : operand shifted left by its leading-zero count (0 for zero)
//   zero    : operand was all zeros
// ---------------------------------------------------------------------------
module mant_norm #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 3,
    parameter int DOT_BITS  = 3
) (
    input  logic [WIDTH-1:0]        operand,
    output logic signed [EXP_WIDTH:0] exp_val,
    output logic [WIDTH-1:0]        mant,
    output logic                    zero
);

    always_comb begin
        int   lzc;
        logic hit;
        lzc     = WIDTH;
        hit     = 1'b0;
        exp_val = '0;
        mant    = '0;
        zero    = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!hit && operand[i]) begin
                hit = 1'b1;
                lzc = WIDTH - 1 - i;
            end
        end
        if (hit) begin
            zero    = 1'b0;
            mant    = operand << lzc;
            // Exponent wraps into EXP_WIDTH+1 bits as two's complement.
            exp_val = (EXP_WIDTH + 1)'(DOT_BITS - 1 - lzc);
        end
    end

endmodule

// File: rtl/mant_norm_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// scanning upward from ptr, wrapping modulo NUM_REQ.
//   req       : request vector
//   ptr       : index with highest priority this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted request (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
    import mant_norm_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mant_norm_sched.sv
// ---------------------------------------------------------------------------
// mant_norm_sched
// Shares one mant_norm unit between NUM_REQ requesters. A round-robin
// arbiter picks one requester per cycle into the operand register (p1);
// the normalized result lands in the result register (p2), which drives a
// single tagged valid/ready output.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : requester handshakes and result output (slave side)
// ---------------------------------------------------------------------------
module mant_norm_sched
    import mant_norm_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 3,
    parameter int DOT_BITS  = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mant_norm_sched_if.slave   bus
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          grant_idx;
    logic [ID_W-1:0]          rr_ptr;
    logic                     s1_ready;
    logic                     s2_ready;
    logic                     accept;

    logic                     vld_p1;
    logic [WIDTH-1:0]         operand_p1;
    logic [ID_W-1:0]          id_p1;

    logic                     vld_p2;
    logic [ID_W-1:0]          id_p2;
    logic signed [EXP_WIDTH:0] exp_p2;
    logic [WIDTH-1:0]         mant_p2;
    logic                     zero_p2;

    logic signed [EXP_WIDTH:0] norm_exp;
    logic [WIDTH-1:0]         norm_mant;
    logic                     norm_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (bus.req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A full stage can still take new data when its successor drains this cycle.
    assign s2_ready = !vld_p2 || bus.out_ready_i;
    assign s1_ready = !vld_p1 || s2_ready;
    assign accept   = (|grant) && s1_ready;

    assign bus.req_ready_o = (s1_ready && !rst_i) ? grant : '0;

    // ---- stage p1: arbitration and operand capture ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (accept) begin
                vld_p1 <= 1'b1;
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end else if (s2_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            operand_p1 <= bus.req_operand_i[grant_idx];
            id_p1      <= grant_idx;
        end
    end

    mant_norm #(
        .WIDTH     (WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .DOT_BITS  (DOT_BITS)
    ) u_norm (
        .operand (operand_p1),
        .exp_val (norm_exp),
        .mant    (norm_mant),
        .zero    (norm_zero)
    );

    // ---- stage p2: normalized result register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2  <= 1'b0;
            id_p2   <= '0;
            exp_p2  <= '0;
            mant_p2 <= '0;
            zero_p2 <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                id_p2   <= id_p1;
                exp_p2  <= norm_exp;
                mant_p2 <= norm_mant;
                zero_p2 <= norm_zero;
            end
        end
    end

    assign bus.out_valid_o = vld_p2;
    assign bus.out_id_o    = id_p2;
    assign bus.out_exp_o   = exp_p2;
    assign bus.out_mant_o  = mant_p2;
    assign bus.out_zero_o  = zero_p2;

endmodule

// File: tb/tb_mant_norm_sched.sv
module tb_mant_norm_sched;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mant_norm_sched_if #(.NUM_REQ(N), .WIDTH(8), .EXP_WIDTH(3)) bus ();

    mant_norm_sched #(
        .NUM_REQ   (N),
        .WIDTH     (8),
        .EXP_WIDTH (3),
        .DOT_BITS  (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int         req;
        logic [7:0] op;
        logic [3:0] exp;
        logic [7:0] mant;
        logic       zero;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int g_q[$];
    int g_cyc[$];
    int o_id[$];
    int o_exp[$];
    int o_cyc[$];

    // Exponent of the stream operands 8'h80 >> id.
    logic [3:0] exp_of_id [N] = '{4'h2, 4'h1, 4'h0, 4'hF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cnt;
        logic [3:0] oh;
        oh = '0;
        oh[v.req] = 1'b1;
        @(negedge clk);
        bus.req_operand_i[v.req] = v.op;
        bus.req_valid_i = oh;
        #1;
        cnt = 0;
        while (bus.req_ready_o !== oh && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("vec_grant", {28'd0, bus.req_ready_o}, {28'd0, oh});
        @(posedge clk);
        #1 bus.req_valid_i = '0;
        @(negedge clk);
        chk("vec_latency_gap", {31'd0, bus.out_valid_o}, 32'd0);
        @(negedge clk);
        chk("vec_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("vec_id",    {30'd0, bus.out_id_o}, v.req);
        chk("vec_exp",   {28'd0, bus.out_exp_o}, {28'd0, v.exp});
        chk("vec_mant",  {24'd0, bus.out_mant_o}, {24'd0, v.mant});
        chk("vec_zero",  {31'd0, bus.out_zero_o}, {31'd0, v.zero});
    endtask

    // Per-requester send counts; out_ready_i is low for cycles
    // [stall_from, stall_from+stall_len). Logs grants and output handshakes.
    task automatic stream(input int r0, input int r1, input int r2, input int r3,
                          input int stall_from, input int stall_len, input int ncyc);
        int rem[N];
        logic [3:0] acc;
        logic frz;
        logic [14:0] snap;
        logic [14:0] cur;
        rem = '{r0, r1, r2, r3};
        frz = 1'b0;
        snap = '0;
        g_q.delete(); g_cyc.delete(); o_id.delete(); o_exp.delete(); o_cyc.delete();
        for (int i = 0; i < N; i++) bus.req_operand_i[i] = 8'h80 >> i;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) bus.req_valid_i[i] = (rem[i] > 0);
        bus.out_ready_i = !(0 >= stall_from && 0 < stall_from + stall_len);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            acc = bus.req_valid_i & bus.req_ready_o;
            chk("grant_onehot", {31'd0, $countones(bus.req_ready_o) <= 1}, 32'd1);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    g_q.push_back(i);
                    g_cyc.push_back(c);
                end
            end
            cur = {bus.out_id_o, bus.out_exp_o, bus.out_mant_o, bus.out_zero_o};
            if (bus.out_valid_o && bus.out_ready_i) begin
                o_id.push_back(int'(bus.out_id_o));
                o_exp.push_back(int'({28'd0, bus.out_exp_o}));
                o_cyc.push_back(c);
            end
            if (bus.out_valid_o && !bus.out_ready_i) begin
                if (frz) chk("stall_frozen", {17'd0, cur}, {17'd0, snap});
                snap = cur;
                frz  = 1'b1;
            end else begin
                frz = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) rem[i] = rem[i] - 1;
                bus.req_valid_i[i] = (rem[i] > 0);
            end
            bus.out_ready_i = !((c + 1) >= stall_from && (c + 1) < stall_from + stall_len);
        end
        bus.req_valid_i = '0;
        bus.out_ready_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int exp_seq[6];
        int n_stall;
        vecs[0] = '{0, 8'h20, 4'h0, 8'h80, 1'b0};
        vecs[1] = '{2, 8'h04, 4'hD, 8'h80, 1'b0};
        vecs[2] = '{1, 8'h80, 4'h2, 8'h80, 1'b0};
        vecs[3] = '{3, 8'h00, 4'h0, 8'h00, 1'b1};
        vecs[4] = '{0, 8'h01, 4'hB, 8'h80, 1'b0};
        vecs[5] = '{1, 8'hFF, 4'h2, 8'hFF, 1'b0};
        vecs[6] = '{2, 8'h35, 4'h0, 8'hD4, 1'b0};
        vecs[7] = '{3, 8'h0A, 4'hE, 8'hA0, 1'b0};
        exp_seq = '{0, 1, 2, 3, 0, 1};

        // Reset state, with requests pending to show ready held low.
        rst = 1'b1;
        bus.req_valid_i   = 4'hF;
        bus.req_operand_i = '0;
        bus.out_ready_i   = 1'b1;
        #3;
        chk("rst_ready", {28'd0, bus.req_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rst_id",    {30'd0, bus.out_id_o}, 32'd0);
        chk("rst_exp",   {28'd0, bus.out_exp_o}, 32'd0);
        chk("rst_mant",  {24'd0, bus.out_mant_o}, 32'd0);
        chk("rst_zero",  {31'd0, bus.out_zero_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        bus.req_valid_i = '0;
        rst = 1'b0;

        // Single-transaction vectors.
        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // All requesters streaming, no backpressure.
        do_reset();
        stream(2, 2, 1, 1, 1000, 0, 10);
        chk("rr_grant_count", g_q.size(), 6);
        chk("rr_out_count", o_id.size(), 6);
        for (int k = 0; k < 6 && k < g_q.size(); k++) begin
            chk("rr_grant_id", g_q[k], exp_seq[k]);
            chk("rr_grant_cycle", g_cyc[k], k);
        end
        for (int k = 0; k < 6 && k < o_id.size(); k++) begin
            chk("rr_out_id", o_id[k], exp_seq[k]);
            chk("rr_out_cycle", o_cyc[k], k + 2);
            chk("rr_out_exp", o_exp[k], {28'd0, exp_of_id[exp_seq[k]]});
        end

        // Backpressure from the start: two operands enter, then everything holds.
        do_reset();
        stream(2, 2, 2, 2, 0, 5, 24);
        n_stall = 0;
        for (int k = 0; k < g_cyc.size(); k++) if (g_cyc[k] < 5) n_stall++;
        chk("stall_accepts", n_stall, 2);
        chk("stall_total_grants", g_q.size(), 8);
        chk("stall_total_outs", o_id.size(), 8);
        for (int k = 0; k < 8 && k < o_id.size() && k < g_q.size(); k++) begin
            chk("stall_grant_id", g_q[k], k % 4);
            chk("stall_out_id", o_id[k], g_q[k]);
            chk("stall_out_exp", o_exp[k], {28'd0, exp_of_id[g_q[k]]});
        end
        if (o_cyc.size() > 0) chk("stall_first_out_cycle", o_cyc[0], 5);

        // Reset with two results in flight.
        do_reset();
        for (int i = 0; i < N; i++) bus.req_operand_i[i] = 8'h80 >> i;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        bus.req_valid_i = 4'b0110;
        @(negedge clk);
        chk("mid_first_grant", {28'd0, bus.req_ready_o}, 32'b0010);
        @(negedge clk);
        chk("mid_second_grant", {28'd0, bus.req_ready_o}, 32'b0100);
        @(negedge clk);
        chk("mid_inflight_valid", {31'd0, bus.out_valid_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_async_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("mid_async_id",    {30'd0, bus.out_id_o}, 32'd0);
        chk("mid_async_mant",  {24'd0, bus.out_mant_o}, 32'd0);
        chk("mid_async_ready", {28'd0, bus.req_ready_o}, 32'd0);
        bus.out_ready_i = 1'b1;
        bus.req_valid_i = 4'b1110;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", {28'd0, bus.req_ready_o}, 32'b0010);
        @(posedge clk);
        #1 bus.req_valid_i = '0;
        @(negedge clk);
        chk("post_rst_no_partial", {31'd0, bus.out_valid_o}, 32'd0);
        @(negedge clk);
        chk("post_rst_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("post_rst_id",    {30'd0, bus.out_id_o}, 32'd1);
        chk("post_rst_exp",   {28'd0, bus.out_exp_o}, 32'h1);
        @(negedge clk);
        chk("post_rst_drained", {31'd0, bus.out_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
